rr_arbiter_burst_lock: RTL and testbench
========================================

# rr_arbiter_burst_lock

- Shares one single-port downstream resource (bus, memory port, FIFO write side) between `N` requesters.
- Uses round-robin priority, like the 2-request arbiter, but generalised to `N` inputs.
- Once granted, a requester owns the resource for a whole burst, until it signals its last beat, drops its request, or exceeds a beat limit.
- Sits between requester-side request/last signals and the resource's `res_ready`. It drives the one-hot grant plus a merged `res_valid`.

## Interface

Parameters:
- `N`, default 4: number of requesters, ≥2.
- `MAX_BEATS`, default 8: maximum accepted beats per grant before forced release, ≥1.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Asserted when 0; state clears immediately on assertion. Deassertion is synchronous to `clk`.
- `req`, input, N: request per requester; held high for the whole burst.
- `last`, input, N: marks the final beat of a burst; only meaningful for the current owner.
- `res_ready`, input, 1: resource accepts a beat this cycle.
- `gnt`, output, N: one-hot registered grant; all zeros when idle.
- `gnt_id`, output, `$clog2(N)`: index of current owner; valid while `busy`=1.
- `busy`, output, 1: a grant is active.
- `res_valid`, output, 1: combinational, equals `busy & req[gnt_id]`.
- `timeout`, output, 1: one-cycle pulse on forced release.

## Operation

- **State machine:** two states.
- **IDLE:**
  - `gnt`=0, `busy`=0.
  - If `req` is non-zero, pick the first set bit scanning circularly from `ptr` upward: `ptr`, `ptr+1`, … `N-1`, `0`, … `ptr-1`.
  - At the edge, load `gnt`=onehot(winner) and `gnt_id`=winner, clear the beat counter, and go to BUSY.
  - If `req`=0, stay in IDLE.
- **BUSY, beat acceptance:** a beat is accepted in a cycle where `req[gnt_id]`=1 and `res_ready`=1. Each accepted beat increments the beat counter, which is `$clog2(MAX_BEATS+1)` bits and saturates at `MAX_BEATS`.
- **BUSY, release conditions**, evaluated each cycle in this priority:
  - (a) `req[gnt_id]`=0: abandon.
  - (b) Accepted beat with `last[gnt_id]`=1: normal end.
  - (c) Accepted beat that brings the count to `MAX_BEATS` while `last[gnt_id]`=0: forced release. Assert `timeout` for the following cycle.
- **On release:**
  - Next state is IDLE; `gnt` clears at the same edge.
  - `ptr` ← `gnt_id+1`, wrapping `N-1`→0.
  - The released requester therefore has lowest priority in the next arbitration.
- **Priority pointer:**
  - `ptr` changes only on release.
  - Requests arriving during BUSY wait; they are never preempted in and never lost. Requests are level-sensitive, so this is the requester's responsibility.
- **Ignored inputs:** `last` of non-owners is ignored; `last` without `res_ready` is ignored.
- **Reset:**
  - Clears `gnt`, `gnt_id`, `busy`, `timeout`, `ptr`, the counter, and the state to IDLE.
  - Requester 0 has highest priority after reset.
  - Reset mid-burst drops the grant immediately, with no release pulse.

## Timing

- **Arbitration latency:** `req` sampled at edge k in IDLE gives `gnt` valid from edge k to k+1. `res_valid` can be high in the first grant cycle.
- **Release:** the release-condition edge clears `gnt`. That is followed by exactly one IDLE cycle with `gnt`=0. The next grant appears one edge later, so consecutive bursts are separated by one bubble cycle.
- **Burst throughput:** at full `res_ready`, throughput is one beat per cycle.
- **`timeout`:** high only during the first IDLE cycle after a forced release.
- **`N`=2 with single-beat bursts:** alternating requesters behave like classic 2-way round-robin, with a bubble between grants.

## Test plan

Parameters `N`=4, `MAX_BEATS`=4 unless noted.

1. **Basic arbitration after reset:**
   - Stimulus: release reset; `req`=0101, `res_ready`=1, `last[0]` high on the 2nd beat.
   - Required: `gnt`=0001 for 2 cycles, then 0000 for 1 cycle, then 0100 with `gnt_id`=2.
2. **Fairness rotation:**
   - Stimulus: `req`=1111 held; every requester sends 1-beat bursts (`last`=1).
   - Required: grant order 0001, 0010, 0100, 1000, 0001, …, each separated by one idle cycle. `ptr` wraps 3→0.
3. **Backpressure:**
   - Stimulus: owner 1 (`req`=0010), `res_ready` toggling 1,0,0,1,1 with `last` on the 3rd accepted beat.
   - Required: the grant is held through the stalls and drops after the edge of the 5th cycle. `res_valid`=1 throughout.
4. **Forced release:**
   - Stimulus: `req`=0011, owner 0 never asserts `last`, `res_ready`=1.
   - Required: after 4 accepted beats `gnt` clears and `timeout`=1 for one cycle, then `gnt`=0010.
5. **Abandon:**
   - Stimulus: owner 2 drops `req[2]` mid-burst while `req[3]`=1.
   - Required: `gnt` clears at the next edge, `timeout`=0, next grant is 1000.
6. **Asynchronous reset mid-burst:**
   - Stimulus: pull `rst` low between edges while `gnt`=0100.
   - Required: `gnt`=0, `busy`=0 immediately without a clock. After release with `req`=0101, `gnt`=0001, since `ptr` was reset to 0.

Source files
------------

// File: rtl/rr_arbiter_burst_lock_if.sv
// Requester/resource handshake bundle for the burst-locking round-robin arbiter.
// master: requester side driving req/last/res_ready; slave: the arbiter.
interface rr_arbiter_burst_lock_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          res_ready;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          res_valid;
  logic          timeout;

  modport master (
    output req, last, res_ready,
    input  gnt, gnt_id, busy, res_valid, timeout
  );

  modport slave (
    input  req, last, res_ready,
    output gnt, gnt_id, busy, res_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_burst_lock.sv
// N-way round-robin arbiter that locks the grant for a whole burst,
// releasing on last beat, dropped request, or a beat-count limit.
module rr_arbiter_burst_lock #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  rr_arbiter_burst_lock_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  logic          own_req;
  logic          accept;
  logic          rel;

  // Circular scan starting at ptr_q; first set request wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign own_req = bus.req[id_q];
  assign accept  = own_req & bus.res_ready;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          id_d       = win;
          cnt_d      = '0;
        end
      end
      BUSY: begin
        if (!own_req) begin
          rel = 1'b1;
        end else if (accept) begin
          if (cnt_q != CW'(MAX_BEATS)) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (bus.last[id_q]) begin
            rel = 1'b1;
          end else if (cnt_q == CW'(MAX_BEATS - 1)) begin
            rel   = 1'b1;
            tmo_d = 1'b1;
          end
        end
        // Released owner drops to lowest priority.
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.busy      = (state_q == BUSY);
  assign bus.res_valid = (state_q == BUSY) & own_req;
  assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_burst_lock.sv
// Directed bench for rr_arbiter_burst_lock (N=4, MAX_BEATS=4) with a
// queued scoreboard checked by an independent negedge monitor.
module tb_rr_arbiter_burst_lock;
  logic clk;
  logic rst;

  rr_arbiter_burst_lock_if #(.N(4)) bus ();

  rr_arbiter_burst_lock #(
    .N(4),
    .MAX_BEATS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         vec;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       rv;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs of the current cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (bus.gnt === e.gnt) && (bus.busy === e.busy) &&
           (bus.res_valid === e.rv) && (bus.timeout === e.tmo) &&
           (!e.busy || bus.gnt_id === e.id);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d: got gnt=%b id=%0d busy=%b rv=%b tmo=%b, want gnt=%b id=%0d busy=%b rv=%b tmo=%b",
                 e.vec, bus.gnt, bus.gnt_id, bus.busy, bus.res_valid,
                 bus.timeout, e.gnt, e.id, e.busy, e.rv, e.tmo);
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] l,
                       input logic rd, input logic [3:0] eg,
                       input logic [1:0] ei, input logic eb,
                       input logic erv, input logic et);
    exp_t e;
    bus.req       = r;
    bus.last      = l;
    bus.res_ready = rd;
    e.vec  = vec_no;
    e.gnt  = eg;
    e.id   = ei;
    e.busy = eb;
    e.rv   = erv;
    e.tmo  = et;
    exp_q.push_back(e);
    vec_no++;
  endtask

  // One cycle: apply inputs just after the edge, then wait for the next.
  task automatic step(input logic [3:0] r, input logic [3:0] l,
                      input logic rd, input logic [3:0] eg,
                      input logic [1:0] ei, input logic eb,
                      input logic erv, input logic et);
    #1;
    drive(r, l, rd, eg, ei, eb, erv, et);
    @(posedge clk);
  endtask

  localparam logic [3:0] Z = 4'b0000;

  initial begin
    rst           = 1'b0;
    bus.req       = '0;
    bus.last      = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);

    // reset holds everything idle even with requests pending
    step(4'b0101, Z, 1'b1, Z, 2'd0, 0, 0, 0);
    step(4'b0101, Z, 1'b1, Z, 2'd0, 0, 0, 0);

    // 1: basic arbitration after reset
    #1 rst = 1'b1;
    step(4'b0101, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b0101, Z,       1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0101, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b0101, 4'b0100, 1'b1, 4'b0100, 2'd2, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    // 2: fairness rotation from ptr=3, wrapping to 0
    step(4'b1111, 4'b1111, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1, 1, 0);
    step(4'b1111, 4'b1111, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b1111, 4'b1111, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b1111, 4'b1111, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1, 1, 0);
    step(4'b1111, 4'b1111, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    // 3: backpressure on owner 1; stalled last and foreign last ignored
    step(4'b0010, Z,       1'b0, Z,       2'd0, 0, 0, 0);
    step(4'b0010, Z,       1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b0010, Z,       1'b0, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b0010, 4'b1000, 1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    // 4: forced release after 4 beats, timeout pulse, then requester 1
    step(4'b0011, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b0011, Z,       1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0011, Z,       1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0011, Z,       1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0011, Z,       1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(4'b0011, Z,       1'b1, Z,       2'd0, 0, 0, 1);
    step(4'b0011, 4'b0010, 1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    // 5: owner 2 abandons, requester 3 next, no timeout
    step(4'b1100, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1100, Z,       1'b1, 4'b0100, 2'd2, 1, 1, 0);
    step(4'b1000, Z,       1'b1, 4'b0100, 2'd2, 1, 0, 0);
    step(4'b1000, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    // 6: move ptr to 2, grant 2, then async reset mid-burst
    step(4'b0010, 4'b0010, 1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b0110, 4'b0010, 1'b1, 4'b0010, 2'd1, 1, 1, 0);
    step(4'b0100, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    step(4'b0100, Z,       1'b1, 4'b0100, 2'd2, 1, 1, 0);
    #1;
    drive(4'b0101, Z, 1'b1, Z, 2'd0, 0, 0, 0);
    #2 rst = 1'b0;
    @(posedge clk);
    step(4'b0101, Z,       1'b1, Z,       2'd0, 0, 0, 0);
    #1 rst = 1'b1;
    drive(4'b0101, Z, 1'b1, Z, 2'd0, 0, 0, 0);
    @(posedge clk);
    step(4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1, 1, 0);
    step(Z,       Z,       1'b0, Z,       2'd0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
